// File: rtl/tart_block_control_if.sv
// Handshake and address bundle between the front-end/readout side (master) and tart_block_control (slave).
// Plain wires: every registered/combinational property is defined by the block that drives them.
interface tart_block_control_if #(
  parameter int COUNT = 24,
  parameter int TBITS = 4,
  parameter int XBITS = 4
);
  logic             en_i;
  logic [COUNT-1:0] blocksize_i;
  logic             strobe_i;
  logic             valid_i;
  logic             ack_i;
  logic [TBITS-1:0] rd_adr_o;
  logic [TBITS-1:0] wr_adr_o;
  logic             rd_wrap_o;
  logic             wr_wrap_o;
  logic             clear_o;
  logic [XBITS-1:0] block_o;
  logic             swap_o;
  logic             ready_o;
  logic [XBITS-1:0] rdblk_o;
  logic             overflow_o;
  logic [7:0]       drops_o;

  modport master (
    output en_i, blocksize_i, strobe_i, valid_i, ack_i,
    input  rd_adr_o, wr_adr_o, rd_wrap_o, wr_wrap_o, clear_o, block_o,
           swap_o, ready_o, rdblk_o, overflow_o, drops_o
  );

  modport slave (
    input  en_i, blocksize_i, strobe_i, valid_i, ack_i,
    output rd_adr_o, wr_adr_o, rd_wrap_o, wr_wrap_o, clear_o, block_o,
           swap_o, ready_o, rdblk_o, overflow_o, drops_o
  );
endinterface

// File: rtl/tart_block_control.sv
// Visibility-accumulation stream controller: RMW slot addressing, sample blocking, SRAM bank rotation, readout handshake.
// Registered outputs except the wrap flags; readout never stalls accumulation (late acks raise overflow). Option: TART_DROP_COUNT_EN.
module tart_block_control #(
  parameter int COUNT = 24,
  parameter int TRATE = 12,
  parameter int TBITS = 4,
  parameter int XBITS = 4,
  parameter int DELAY = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tart_block_control_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, PEND} state_e;

  localparam logic [TBITS-1:0] SLOT_LAST = TBITS'(TRATE - 1);

  if ((2 ** TBITS) < TRATE || DELAY < 0) begin : g_bad_params
    $error("tart_block_control: TBITS too narrow for TRATE, or negative DELAY");
  end

  state_e           state_q, state_d;
  logic [TBITS-1:0] rd_adr_q, rd_adr_d;
  logic [TBITS-1:0] mid_adr_q, mid_adr_d;
  logic [TBITS-1:0] wr_adr_q, wr_adr_d;
  logic [COUNT-1:0] cnt_q, cnt_d;
  logic [COUNT-1:0] bs_q, bs_d;
  logic             sw_q, sw_d;
  logic             clear_q, clear_d;
  logic             swap_q, swap_d;
  logic             ready_q, ready_d;
  logic             ovf_q, ovf_d;
  logic [XBITS-1:0] block_q, block_d;
  logic [XBITS-1:0] rdblk_q, rdblk_d;
  logic             rd_wrap;
  logic             wr_wrap;
  logic             bank_done;

  assign rd_wrap = bus.valid_i && (rd_adr_q == SLOT_LAST);
  assign wr_wrap = bus.valid_i && (wr_adr_q == SLOT_LAST);

  // Write slot trails the read slot by the two RMW pipeline stages.
  always_comb begin
    rd_adr_d  = rd_adr_q;
    mid_adr_d = mid_adr_q;
    wr_adr_d  = wr_adr_q;
    if (bus.valid_i) begin
      rd_adr_d  = (rd_adr_q == SLOT_LAST) ? '0 : rd_adr_q + 1'b1;
      mid_adr_d = rd_adr_q;
      wr_adr_d  = mid_adr_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bs_d      = bs_q;
    sw_d      = sw_q;
    swap_d    = 1'b0;
    bank_done = 1'b0;
    if (!bus.en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      sw_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = CLEAR;
        end
        CLEAR: begin
          // Commit only after the last write of the finished pass has landed.
          if (sw_q && wr_wrap) begin
            bank_done = 1'b1;
            sw_d      = 1'b0;
          end
          if (rd_wrap) begin
            state_d = FILL;
            cnt_d   = '0;
            bs_d    = bus.blocksize_i;
          end
        end
        FILL: begin
          if (bus.strobe_i) begin
            if (cnt_q == bs_q) begin
              cnt_d   = '0;
              state_d = PEND;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        PEND: begin
          if (bus.strobe_i) cnt_d = cnt_q + 1'b1;
          if (rd_wrap) begin
            state_d = CLEAR;
            sw_d    = 1'b1;
            swap_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign clear_d = (state_d == IDLE) || (state_d == CLEAR);

  // A completion coinciding with ack hands over cleanly; otherwise a pending bank is lost.
  always_comb begin
    ready_d = ready_q;
    rdblk_d = rdblk_q;
    block_d = block_q;
    ovf_d   = ovf_q;
    if (bus.ack_i) ready_d = 1'b0;
    if (bank_done) begin
      rdblk_d = block_q;
      block_d = block_q + 1'b1;
      ready_d = 1'b1;
      if (ready_q && !bus.ack_i) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rd_adr_q  <= '0;
      mid_adr_q <= '0;
      wr_adr_q  <= '0;
      cnt_q     <= '0;
      bs_q      <= '0;
      sw_q      <= 1'b0;
      clear_q   <= 1'b1;
      swap_q    <= 1'b0;
      ready_q   <= 1'b0;
      ovf_q     <= 1'b0;
      block_q   <= '0;
      rdblk_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_adr_q  <= rd_adr_d;
      mid_adr_q <= mid_adr_d;
      wr_adr_q  <= wr_adr_d;
      cnt_q     <= cnt_d;
      bs_q      <= bs_d;
      sw_q      <= sw_d;
      clear_q   <= clear_d;
      swap_q    <= swap_d;
      ready_q   <= ready_d;
      ovf_q     <= ovf_d;
      block_q   <= block_d;
      rdblk_q   <= rdblk_d;
    end
  end

`ifdef TART_DROP_COUNT_EN
  logic       drop_evt;
  logic [7:0] drops_q, drops_d;

  assign drop_evt = bank_done && ready_q && !bus.ack_i;

  always_comb begin
    drops_d = drops_q;
    if (drop_evt && (drops_q != 8'hFF)) drops_d = drops_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drops_q <= 8'h00;
    else         drops_q <= drops_d;
  end

  assign bus.drops_o = drops_q;
`else
  assign bus.drops_o = 8'h00;
`endif

  assign bus.rd_adr_o   = rd_adr_q;
  assign bus.wr_adr_o   = wr_adr_q;
  assign bus.rd_wrap_o  = rd_wrap;
  assign bus.wr_wrap_o  = wr_wrap;
  assign bus.clear_o    = clear_q;
  assign bus.block_o    = block_q;
  assign bus.swap_o     = swap_q;
  assign bus.ready_o    = ready_q;
  assign bus.rdblk_o    = rdblk_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_tart_block_control.sv
// Bench for tart_block_control: slot-address vector table plus scoreboarded block/bank scenarios.
module tb_tart_block_control;
  localparam int COUNT = 24;
  localparam int TRATE = 12;
  localparam int TBITS = 4;
  localparam int XBITS = 4;
`ifdef TART_DROP_COUNT_EN
  localparam int EXP_DROPS = 2;
`else
  localparam int EXP_DROPS = 0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  tart_block_control_if #(.COUNT(COUNT), .TBITS(TBITS), .XBITS(XBITS)) bus ();

  tart_block_control #(
    .COUNT(COUNT), .TRATE(TRATE), .TBITS(TBITS), .XBITS(XBITS), .DELAY(3)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  typedef struct {
    bit valid;
    int rd;
    int wr;
    bit rw;
    bit ww;
  } vec_t;

  typedef struct {
    int rdblk;
    int blk;
    int due;
  } bank_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc;
  int    sb_t0;
  int    sb_bs;
  int    exp_blk;
  int    swaps;
  bit    auto_ack;
  bit    force_ack;
  logic [XBITS-1:0] prev_blk;
  bank_t q[$];
  vec_t  tv[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".rd_adr"},   32'(bus.rd_adr_o),   0);
    chk({tag, ".wr_adr"},   32'(bus.wr_adr_o),   0);
    chk({tag, ".clear"},    32'(bus.clear_o),    1);
    chk({tag, ".block"},    32'(bus.block_o),    0);
    chk({tag, ".swap"},     32'(bus.swap_o),     0);
    chk({tag, ".ready"},    32'(bus.ready_o),    0);
    chk({tag, ".rdblk"},    32'(bus.rdblk_o),    0);
    chk({tag, ".overflow"}, 32'(bus.overflow_o), 0);
    chk({tag, ".drops"},    32'(bus.drops_o),    0);
  endtask

  task automatic do_reset();
    rst_ni           = 1'b0;
    bus.en_i         = 1'b0;
    bus.strobe_i     = 1'b0;
    bus.ack_i        = 1'b0;
    bus.valid_i      = 1'b1;
    bus.blocksize_i  = '0;
    q.delete();
    exp_blk   = 0;
    prev_blk  = '0;
    cyc       = 0;
    sb_t0     = 0;
    sb_bs     = 0;
    swaps     = 0;
    auto_ack  = 1'b0;
    force_ack = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // One clock: drive strobe/ack, push expected bank commits, then score what the DUT shows.
  task automatic step();
    int    rel;
    int    per;
    int    first;
    bit    acked;
    logic [XBITS-1:0] old_blk;
    bank_t e;
    bus.strobe_i = (cyc % TRATE == 0);
    rel   = cyc - sb_t0;
    first = TRATE * (sb_bs + 1);
    per   = TRATE * (sb_bs + 2);
    if (bus.strobe_i && bus.en_i && rel >= first && ((rel - first) % per) == 0) begin
      e.rdblk = exp_blk;
      e.blk   = (exp_blk + 1) % (1 << XBITS);
      e.due   = cyc + 14;
      q.push_back(e);
      exp_blk = e.blk;
    end
    bus.ack_i = force_ack || (auto_ack && bus.ready_o);
    acked     = bus.ack_i && !force_ack;
    old_blk   = prev_blk;
    @(posedge clk_i);
    #1;
    cyc++;
    if (bus.swap_o) swaps++;
    if (bus.block_o != prev_blk) begin
      prev_blk = bus.block_o;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bank.unexpected: block_o=%0d at cycle %0d, none expected", bus.block_o, cyc);
      end else begin
        e = q.pop_front();
        chk("bank.rdblk", 32'(bus.rdblk_o), e.rdblk);
        chk("bank.block", 32'(bus.block_o), e.blk);
        chk("bank.cycle", cyc, e.due);
      end
    end else if (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL bank.timeout: no commit by cycle %0d, expected at %0d", cyc, q[0].due);
      void'(q.pop_front());
    end
    if (acked && bus.block_o == old_blk) chk("ack.ready_clear", 32'(bus.ready_o), 0);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{1, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 0, 0, 0};
    tv[2]  = '{1, 1, 0, 0, 0};
    tv[3]  = '{1, 2, 0, 0, 0};
    tv[4]  = '{1, 3, 1, 0, 0};
    tv[5]  = '{1, 4, 2, 0, 0};
    tv[6]  = '{1, 5, 3, 0, 0};
    tv[7]  = '{1, 6, 4, 0, 0};
    tv[8]  = '{1, 7, 5, 0, 0};
    tv[9]  = '{1, 8, 6, 0, 0};
    tv[10] = '{1, 9, 7, 0, 0};
    tv[11] = '{1, 10, 8, 0, 0};
    tv[12] = '{0, 11, 9, 0, 0};
    tv[13] = '{1, 11, 9, 1, 0};
    tv[14] = '{1, 0, 10, 0, 0};
    tv[15] = '{0, 1, 11, 0, 0};
    tv[16] = '{1, 1, 11, 0, 1};
    tv[17] = '{1, 2, 0, 0, 0};

    // Reset values and slot addressing with gaps in valid_i (acquisition disabled).
    do_reset();
    check_reset("reset");
    for (int i = 0; i < 18; i++) begin
      logic [9:0] act;
      logic [9:0] exp;
      bus.valid_i = tv[i].valid;
      #1;
      act = {bus.rd_adr_o, bus.wr_adr_o, bus.rd_wrap_o, bus.wr_wrap_o};
      exp = {4'(tv[i].rd), 4'(tv[i].wr), tv[i].rw, tv[i].ww};
      chk($sformatf("slot.vec%0d", i), 32'(act), 32'(exp));
      @(posedge clk_i);
      #1;
    end

    // Normal block with acks, five blocks of 4 samples.
    do_reset();
    bus.en_i = 1'b1;
    bus.blocksize_i = 24'd3;
    sb_bs = 3;
    auto_ack = 1'b1;
    step();
    chk("en.clear_state", 32'(bus.clear_o), 1);
    run_to(59);
    chk("pre_swap.swap", 32'(bus.swap_o), 0);
    step();
    chk("swap.pulse", 32'(bus.swap_o), 1);
    chk("swap.ready_low", 32'(bus.ready_o), 0);
    step();
    chk("swap.one_cycle", 32'(bus.swap_o), 0);
    chk("swap.wr_wrap", 32'(bus.wr_wrap_o), 1);
    chk("swap.ready_still_low", 32'(bus.ready_o), 0);
    step();
    chk("normal.ready", 32'(bus.ready_o), 1);
    chk("normal.rdblk", 32'(bus.rdblk_o), 0);
    chk("normal.block", 32'(bus.block_o), 1);
    run_to(305);
    chk("ack.swaps", swaps, 5);
    chk("ack.overflow", 32'(bus.overflow_o), 0);
    chk("ack.queue_empty", q.size(), 0);

    // Overflow: never acknowledge, three blocks.
    do_reset();
    bus.en_i = 1'b1;
    bus.blocksize_i = 24'd3;
    sb_bs = 3;
    run_to(121);
    chk("ovf.before_2nd", 32'(bus.overflow_o), 0);
    step();
    chk("ovf.after_2nd", 32'(bus.overflow_o), 1);
    run_to(185);
    chk("ovf.rdblk", 32'(bus.rdblk_o), 2);
    chk("ovf.block", 32'(bus.block_o), 3);
    chk("ovf.sticky", 32'(bus.overflow_o), 1);
    chk("ovf.drops", 32'(bus.drops_o), EXP_DROPS);
    chk("ovf.queue_empty", q.size(), 0);

    // Ack in the very cycle the second bank commits.
    do_reset();
    bus.en_i = 1'b1;
    bus.blocksize_i = 24'd3;
    sb_bs = 3;
    run_to(121);
    chk("simul.ready_before", 32'(bus.ready_o), 1);
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    chk("simul.ready", 32'(bus.ready_o), 1);
    chk("simul.overflow", 32'(bus.overflow_o), 0);
    chk("simul.drops", 32'(bus.drops_o), 0);
    run_to(130);
    chk("simul.queue_empty", q.size(), 0);

    // Blocksize 0, disable during FILL, re-enable with blocksize 1.
    do_reset();
    bus.en_i = 1'b1;
    bus.blocksize_i = '0;
    sb_bs = 0;
    auto_ack = 1'b1;
    run_to(84);
    chk("bs0.in_fill", 32'(bus.clear_o), 0);
    chk("bs0.block", 32'(bus.block_o), 3);
    bus.en_i = 1'b0;
    step();
    chk("dis.idle_clear", 32'(bus.clear_o), 1);
    chk("dis.block_held", 32'(bus.block_o), 3);
    run_to(96);
    chk("dis.still_held", 32'(bus.block_o), 3);
    chk("dis.no_swap", swaps, 3);
    bus.en_i = 1'b1;
    bus.blocksize_i = 24'd1;
    sb_t0 = 96;
    sb_bs = 1;
    run_to(185);
    chk("reen.block", 32'(bus.block_o), 5);
    chk("reen.overflow", 32'(bus.overflow_o), 0);
    chk("reen.queue_empty", q.size(), 0);

    // Asynchronous reset in the middle of FILL, checked before any clock edge.
    chk("prereset.in_fill", 32'(bus.clear_o), 0);
    #2 rst_ni = 1'b0;
    #1;
    check_reset("async");
    #20 rst_ni = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
